// File: rtl/clock_set_ctrl_if.sv
// Button/tick inputs and control outputs of the clock-setting controller.
interface clock_set_ctrl_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_clr;
  logic       run_tick;
  logic       adjust_sec;
  logic       adjust_min;
  logic       adjust_hour;
  logic       clear;
  logic       keep;
  logic [1:0] mode;
  logic       blink;

  modport master (
    output tick, btn_mode, btn_inc, btn_clr,
    input  run_tick, adjust_sec, adjust_min, adjust_hour, clear, keep, mode, blink
  );

  modport slave (
    input  tick, btn_mode, btn_inc, btn_clr,
    output run_tick, adjust_sec, adjust_min, adjust_hour, clear, keep, mode, blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Clock-setting controller: mode FSM, increment with auto-repeat, idle timeout
// back to RUN, and field blink generation. All outputs are registered.
module clock_set_ctrl #(
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 100,
  parameter int unsigned IDLE_TIMEOUT  = 10000,
  parameter int unsigned BLINK_HALF    = 250
) (
  input logic             clk,
  input logic             rst_n,
  clock_set_ctrl_if.slave bus
);

  // One repeat counter serves both the initial delay and the period.
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam int unsigned IdleW  = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StSetHour = 2'd1,
    StSetMin  = 2'd2,
    StSetSec  = 2'd3
  } state_e;

  state_e            st_q, st_d;
  logic              mode_q, inc_q, clr_q;
  logic              armed_q;
  logic              press_mode, press_inc, press_clr, any_press;
  logic [RepW-1:0]   rep_cnt_q, rep_cnt_d;
  logic              rep_act_q, rep_act_d;
  logic              rep_per_q, rep_per_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic [BlinkW-1:0] bcnt_q, bcnt_d;
  logic              bph_q, bph_d;
  logic              adj_fire;
  logic              run_tick_q, run_tick_d;
  logic              adj_hour_q, adj_hour_d;
  logic              adj_min_q, adj_min_d;
  logic              adj_sec_q, adj_sec_d;
  logic              clear_q, clear_d;
  logic              keep_q, keep_d;
  logic              blink_q, blink_d;

  // armed_q masks the first cycle after reset so an already-held button is not a press.
  assign press_mode = armed_q & bus.btn_mode & ~mode_q;
  assign press_inc  = armed_q & bus.btn_inc  & ~inc_q;
  assign press_clr  = armed_q & bus.btn_clr  & ~clr_q;
  assign any_press  = press_mode | press_inc | press_clr;

  // Button history registers for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 1'b0;
      inc_q   <= 1'b0;
      clr_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      mode_q  <= bus.btn_mode;
      inc_q   <= bus.btn_inc;
      clr_q   <= bus.btn_clr;
      armed_q <= 1'b1;
    end
  end

  // Next state, repeat/idle/blink counters and output pulses.
  always_comb begin
    st_d      = st_q;
    rep_cnt_d = rep_cnt_q;
    rep_act_d = rep_act_q;
    rep_per_d = rep_per_q;
    idle_d    = idle_q;
    bcnt_d    = bcnt_q;
    bph_d     = bph_q;
    adj_fire  = 1'b0;
    clear_d   = 1'b0;

    // Priority: clear, then mode, then increment.
    if (press_clr) begin
      clear_d   = 1'b1;
      st_d      = StRun;
      rep_act_d = 1'b0;
    end else if (press_mode) begin
      unique case (st_q)
        StRun:     st_d = StSetHour;
        StSetHour: st_d = StSetMin;
        StSetMin:  st_d = StSetSec;
        StSetSec:  st_d = StRun;
      endcase
      rep_act_d = 1'b0;
    end else if (st_q == StRun || !bus.btn_inc) begin
      rep_act_d = 1'b0;
    end else if (press_inc) begin
      adj_fire  = 1'b1;
      rep_act_d = 1'b1;
      rep_per_d = 1'b0;
      rep_cnt_d = RepW'(1);
    end else if (rep_act_q) begin
      if (rep_cnt_q != RepW'(RepMax)) rep_cnt_d = rep_cnt_q + 1'b1;
      // Counter is 1 the cycle after a pulse decision, so the first repeat
      // lands REPEAT_DELAY cycles after the press itself.
      if ((!rep_per_q && rep_cnt_q == RepW'(REPEAT_DELAY - 1)) ||
          ( rep_per_q && rep_cnt_q == RepW'(REPEAT_PERIOD))) begin
        adj_fire  = 1'b1;
        rep_per_d = 1'b1;
        rep_cnt_d = RepW'(1);
      end
    end

    // Idle timeout: any press or a held inc counts as activity.
    if (st_q == StRun || any_press || bus.btn_inc) begin
      idle_d = '0;
    end else if (idle_q != IdleW'(IDLE_TIMEOUT)) begin
      idle_d = idle_q + 1'b1;
    end
    if (st_q != StRun && idle_d == IdleW'(IDLE_TIMEOUT)) begin
      st_d      = StRun;
      idle_d    = '0;
      rep_act_d = 1'b0;
    end

    if (!rep_act_d) begin
      rep_cnt_d = '0;
      rep_per_d = 1'b0;
    end

    // Blink phase restarts low on entry to any set state.
    if (st_d == StRun || st_d != st_q) begin
      bcnt_d = '0;
      bph_d  = 1'b0;
    end else if (bcnt_q == BlinkW'(BLINK_HALF - 1)) begin
      bcnt_d = '0;
      bph_d  = ~bph_q;
    end else begin
      bcnt_d = bcnt_q + 1'b1;
    end

    run_tick_d = bus.tick & (st_q == StRun);
    adj_hour_d = adj_fire & (st_q == StSetHour);
    adj_min_d  = adj_fire & (st_q == StSetMin);
    adj_sec_d  = adj_fire & (st_q == StSetSec);
    keep_d     = (st_d != StRun);
    blink_d    = bph_d & ~adj_fire & (st_d != StRun);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= StRun;
      rep_cnt_q  <= '0;
      rep_act_q  <= 1'b0;
      rep_per_q  <= 1'b0;
      idle_q     <= '0;
      bcnt_q     <= '0;
      bph_q      <= 1'b0;
      run_tick_q <= 1'b0;
      adj_hour_q <= 1'b0;
      adj_min_q  <= 1'b0;
      adj_sec_q  <= 1'b0;
      clear_q    <= 1'b0;
      keep_q     <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      st_q       <= st_d;
      rep_cnt_q  <= rep_cnt_d;
      rep_act_q  <= rep_act_d;
      rep_per_q  <= rep_per_d;
      idle_q     <= idle_d;
      bcnt_q     <= bcnt_d;
      bph_q      <= bph_d;
      run_tick_q <= run_tick_d;
      adj_hour_q <= adj_hour_d;
      adj_min_q  <= adj_min_d;
      adj_sec_q  <= adj_sec_d;
      clear_q    <= clear_d;
      keep_q     <= keep_d;
      blink_q    <= blink_d;
    end
  end

  assign bus.run_tick    = run_tick_q;
  assign bus.adjust_hour = adj_hour_q;
  assign bus.adjust_min  = adj_min_q;
  assign bus.adjust_sec  = adj_sec_q;
  assign bus.clear       = clear_q;
  assign bus.keep        = keep_q;
  assign bus.mode        = st_q;
  assign bus.blink       = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with a cycle-level reference model.
module tb_clock_set_ctrl;
  localparam int RD = 500;
  localparam int RP = 100;
  localparam int IT = 10000;
  localparam int BH = 250;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  clock_set_ctrl_if bus ();

  clock_set_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [8:0] dut_vec;
  assign dut_vec = {bus.run_tick, bus.adjust_hour, bus.adjust_min, bus.adjust_sec,
                    bus.clear, bus.keep, bus.mode, bus.blink};

  // Reference model state: ages are measured in absolute cycles.
  logic [8:0] exp_vec = '0;
  int  m_mode = 0, idle = 0, bage = 0, cyc = 0, hold_start = 0;
  bit  pb_mode = 0, pb_inc = 0, pb_clr = 0, armed = 0, holding = 0;

  task automatic model_update();
    bit pm, pi, pc, fire, e_rt, e_clr, e_blink;
    int nm, age;
    if (!rst_n) begin
      m_mode = 0; idle = 0; bage = 0; cyc = 0; holding = 0;
      pb_mode = 0; pb_inc = 0; pb_clr = 0; armed = 0;
      exp_vec = '0;
    end else begin
      pm = armed && bus.btn_mode && !pb_mode;
      pi = armed && bus.btn_inc && !pb_inc;
      pc = armed && bus.btn_clr && !pb_clr;
      e_rt = bus.tick && (m_mode == 0);
      fire = 0; e_clr = 0; nm = m_mode;
      if (pc) begin
        e_clr = 1; nm = 0; holding = 0;
      end else if (pm) begin
        nm = (m_mode + 1) % 4; holding = 0;
      end else if (m_mode == 0 || !bus.btn_inc) begin
        holding = 0;
      end else if (pi) begin
        fire = 1; holding = 1; hold_start = cyc;
      end else if (holding) begin
        age = cyc - hold_start + 1;  // output-cycle offset from the press
        if (age == RD || (age > RD && (age - RD) % RP == 0)) fire = 1;
      end
      if (m_mode == 0 || pm || pi || pc || bus.btn_inc) idle = 0;
      else idle++;
      if (nm != 0 && idle >= IT) begin
        nm = 0; idle = 0; holding = 0;
      end
      if (nm == 0 || nm != m_mode) bage = 0;
      else bage++;
      e_blink = (nm != 0) && ((bage / BH) % 2 == 1) && !fire;
      exp_vec = {e_rt, fire && m_mode == 1, fire && m_mode == 2, fire && m_mode == 3,
                 e_clr, nm != 0, 2'(nm), e_blink};
      m_mode = nm;
      pb_mode = bus.btn_mode; pb_inc = bus.btn_inc; pb_clr = bus.btn_clr;
      armed = 1;
      cyc++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_update();
    end
  end

  task automatic idle_inputs();
    bus.tick = 0; bus.btn_mode = 0; bus.btn_inc = 0; bus.btn_clr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.tick = 1; bus.btn_mode = 1; bus.btn_inc = 1; bus.btn_clr = 1;
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== 9'd0) begin
        errors++; $display("FAIL reset_outputs: cycle %0d got %b expected 000000000", i, dut_vec);
      end
    end
    bus.tick = 0;
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL reset_held_btn: cycle %0d got %b expected %b", i, dut_vec, exp_vec);
      end
      checks++;
      if (bus.mode !== 2'd0 || bus.clear !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_press: cycle %0d mode=%0d clear=%b expected mode=0 clear=0",
                 i, bus.mode, bus.clear);
      end
    end
    idle_inputs();
  endtask

  task automatic test_run_ticks();
    int n_rt = 0, n_adj = 0, n_keep = 0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL run_ticks: cycle %0d got %b expected %b", i, dut_vec, exp_vec);
      end
      n_rt += int'(bus.run_tick);
      n_adj += int'(bus.adjust_hour) + int'(bus.adjust_min) + int'(bus.adjust_sec);
      n_keep += int'(bus.keep);
      bus.tick = (i == 2 || i == 5 || i == 8);
    end
    checks++;
    if (n_rt != 3 || n_adj != 0 || n_keep != 0) begin
      errors++;
      $display("FAIL run_ticks_count: run_tick=%0d adj=%0d keep=%0d expected 3 0 0",
               n_rt, n_adj, n_keep);
    end
  endtask

  task automatic test_set_min();
    int n_min = 0, n_oth = 0, n_rt = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL set_min: cycle %0d got %b expected %b", i, dut_vec, exp_vec);
      end
      n_min += int'(bus.adjust_min);
      n_oth += int'(bus.adjust_hour) + int'(bus.adjust_sec) + int'(bus.clear);
      n_rt += int'(bus.run_tick);
      bus.btn_mode = (i == 1 || i == 3);
      bus.btn_inc = (i == 6);
      bus.tick = (i == 8 || i == 9 || i == 12);
    end
    checks++;
    if (bus.mode !== 2'd2 || bus.keep !== 1'b1 || n_min != 1 || n_oth != 0 || n_rt != 0) begin
      errors++;
      $display("FAIL set_min_final: mode=%0d keep=%b min=%0d other=%0d run_tick=%0d expected 2 1 1 0 0",
               bus.mode, bus.keep, n_min, n_oth, n_rt);
    end
    idle_inputs();
  endtask

  task automatic test_repeat();
    int n_hour = 0;
    bit want;
    do_reset();
    for (int i = 0; i < 830; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL repeat: cycle %0d got %b expected %b", i, dut_vec, exp_vec);
      end
      want = (i == 6 || i == 505 || i == 605 || i == 705 || i == 805);
      checks++;
      if (bus.adjust_hour !== want) begin
        errors++;
        $display("FAIL repeat_timing: offset %0d adjust_hour=%b expected %b", i - 5,
                 bus.adjust_hour, want);
      end
      n_hour += int'(bus.adjust_hour);
      bus.btn_mode = (i == 1);
      bus.btn_inc = (i >= 5 && i < 805);
    end
    checks++;
    if (n_hour != 5) begin
      errors++; $display("FAIL repeat_count: adjust_hour pulses=%0d expected 5", n_hour);
    end
    idle_inputs();
  endtask

  task automatic test_idle_timeout();
    int n_pulse = 0;
    do_reset();
    for (int i = 0; i < 10012; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL idle: cycle %0d got %b expected %b", i, dut_vec, exp_vec);
      end
      if (i == 10005 || i == 10006) begin
        checks++;
        if (bus.mode !== ((i == 10005) ? 2'd3 : 2'd0)) begin
          errors++; $display("FAIL idle_edge: cycle %0d mode=%0d", i, bus.mode);
        end
      end
      n_pulse += int'(bus.adjust_hour) + int'(bus.adjust_min) + int'(bus.adjust_sec)
               + int'(bus.clear);
      bus.btn_mode = (i == 1 || i == 3 || i == 5);
    end
    checks++;
    if (bus.mode !== 2'd0 || bus.keep !== 1'b0 || n_pulse != 0) begin
      errors++;
      $display("FAIL idle_final: mode=%0d keep=%b pulses=%0d expected 0 0 0",
               bus.mode, bus.keep, n_pulse);
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    int n_clr = 0, n_adj = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL simul: cycle %0d got %b expected %b", i, dut_vec, exp_vec);
      end
      if (i == 7) begin
        checks++;
        if (bus.clear !== 1'b1 || bus.mode !== 2'd0) begin
          errors++;
          $display("FAIL simul_clear: clear=%b mode=%0d expected 1 0", bus.clear, bus.mode);
        end
      end
      n_clr += int'(bus.clear);
      n_adj += int'(bus.adjust_hour) + int'(bus.adjust_min) + int'(bus.adjust_sec);
      bus.btn_mode = (i == 1 || i == 3 || i == 6);
      bus.btn_clr = (i == 6);
      bus.btn_inc = (i == 6);
    end
    checks++;
    if (n_clr != 1 || n_adj != 0) begin
      errors++; $display("FAIL simul_count: clear=%0d adj=%0d expected 1 0", n_clr, n_adj);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_repeat();
    int n_before = 0, n_after = 0;
    do_reset();
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      checks++;
      if (!rst_n) begin
        if (dut_vec !== 9'd0) begin
          errors++; $display("FAIL mid_rst_outputs: cycle %0d got %b expected 0", i, dut_vec);
        end
      end else if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL mid_rst: cycle %0d got %b expected %b", i, dut_vec, exp_vec);
      end
      if (i < 520) n_before += int'(bus.adjust_hour);
      else n_after += int'(bus.adjust_hour) + int'(bus.adjust_min) + int'(bus.adjust_sec);
      bus.btn_mode = (i == 1);
      bus.btn_inc = (i >= 4);
      if (i == 520) rst_n = 0;
      if (i == 525) rst_n = 1;
    end
    checks++;
    if (n_before != 2 || n_after != 0 || bus.mode !== 2'd0) begin
      errors++;
      $display("FAIL mid_rst_count: before=%0d after=%0d mode=%0d expected 2 0 0",
               n_before, n_after, bus.mode);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL random: cycle %0d got %b expected %b", i, dut_vec, exp_vec);
      end
      bus.tick = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 149) == 0) bus.btn_mode = ~bus.btn_mode;
      if ($urandom_range(0, 699) == 0) bus.btn_inc = ~bus.btn_inc;
      if ($urandom_range(0, 799) == 0) bus.btn_clr = ~bus.btn_clr;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_run_ticks();
    test_set_min();
    test_repeat();
    test_idle_timeout();
    test_simultaneous();
    test_reset_mid_repeat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
